// File: rtl/riscv_hwloop_pkg.sv
// rtl/riscv_hwloop_pkg.sv - shared types and constants for the hardware-loop sequencer
// Contents: setup FSM state enum, per-loop context struct, address alignment mask.
package riscv_hwloop_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2
    } setup_state_e;

    // One hardware-loop context. "end" is a keyword, hence end_addr.
    typedef struct packed {
        logic [31:0] start;
        logic [31:0] end_addr;
        logic [31:0] count;
        logic        active;
    } hwlp_ctx_t;

    // Loop boundaries must be word aligned; any bit set here rejects a setup.
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/riscv_hwloop_match.sv
// rtl/riscv_hwloop_match.sv - end-address compare with lowest-index priority select
// Ports:
//   pc, pc_valid         : instruction address in ID and its advance qualifier
//   ctx[N_LOOPS]         : loop contexts
//   hit                  : at least one active loop ends at pc
//   win_idx              : index of the winning (innermost) loop
//   win_start, win_count : start address and remaining count of the winner
module riscv_hwloop_match
    import riscv_hwloop_pkg::*;
#(
    parameter int N_LOOPS = 2,
    parameter int IDX_W   = 1
) (
    input  logic [31:0]      pc,
    input  logic             pc_valid,
    input  hwlp_ctx_t        ctx [N_LOOPS],
    output logic             hit,
    output logic [IDX_W-1:0] win_idx,
    output logic [31:0]      win_start,
    output logic [31:0]      win_count
);

    // Scan from the highest index down so the lowest matching index is written last.
    always_comb begin
        hit       = 1'b0;
        win_idx   = '0;
        win_start = '0;
        win_count = '0;
        for (int i = N_LOOPS - 1; i >= 0; i--) begin
            if (pc_valid && ctx[i].active && (pc == ctx[i].end_addr)) begin
                hit       = 1'b1;
                win_idx   = IDX_W'(i);
                win_start = ctx[i].start;
                win_count = ctx[i].count;
            end
        end
    end

endmodule

// File: rtl/riscv_hwloop_sequencer.sv
// rtl/riscv_hwloop_sequencer.sv - hardware-loop setup FSM, context storage and jump generation
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   current_pc_i, pc_valid_i    : PC in ID and its advance qualifier
//   setup_valid_i/ready_o       : setup request handshake
//   setup_loop_i, setup_start_i,
//   setup_end_i, setup_count_i  : setup request payload
//   setup_err_o                 : one-cycle pulse on a rejected setup
//   flush_i                     : synchronous clear of all loop contexts
//   hwlp_jump_o, hwlp_targ_addr_o : jump request and target
//   active_o                    : per-loop active flags
module riscv_hwloop_sequencer
    import riscv_hwloop_pkg::*;
#(
    parameter int N_LOOPS = 2,
    parameter int IDX_W   = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        current_pc_i,
    input  logic               pc_valid_i,
    input  logic               setup_valid_i,
    output logic               setup_ready_o,
    input  logic [IDX_W-1:0]   setup_loop_i,
    input  logic [31:0]        setup_start_i,
    input  logic [31:0]        setup_end_i,
    input  logic [31:0]        setup_count_i,
    output logic               setup_err_o,
    input  logic               flush_i,
    output logic               hwlp_jump_o,
    output logic [31:0]        hwlp_targ_addr_o,
    output logic [N_LOOPS-1:0] active_o
);

    setup_state_e     state_q, state_d;
    hwlp_ctx_t        ctx_q [N_LOOPS];
    logic [IDX_W-1:0] stage_loop;
    logic [31:0]      stage_start, stage_end, stage_count;
    logic             reject;

    logic             hit;
    logic [IDX_W-1:0] win_idx;
    logic [31:0]      win_start, win_count;

    riscv_hwloop_match #(
        .N_LOOPS (N_LOOPS),
        .IDX_W   (IDX_W)
    ) u_match (
        .pc        (current_pc_i),
        .pc_valid  (pc_valid_i),
        .ctx       (ctx_q),
        .hit       (hit),
        .win_idx   (win_idx),
        .win_start (win_start),
        .win_count (win_count)
    );

    assign reject = (stage_count == 32'd0)
                 || (stage_end <= stage_start)
                 || ((stage_start & ALIGN_MASK) != 32'd0)
                 || ((stage_end & ALIGN_MASK) != 32'd0)
                 || (32'(stage_loop) >= 32'(N_LOOPS));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup_valid_i) state_d = CHECK;
            CHECK:   state_d = reject ? IDLE : COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // Outputs; ready is masked by rst so it reads 0 throughout reset.
    always_comb begin
        setup_ready_o    = (state_q == IDLE) && !rst;
        setup_err_o      = (state_q == CHECK) && reject;
        hwlp_jump_o      = hit && (win_count > 32'd1);
        hwlp_targ_addr_o = hwlp_jump_o ? win_start : 32'd0;
        for (int i = 0; i < N_LOOPS; i++) active_o[i] = ctx_q[i].active;
    end

    // Staging registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_loop  <= '0;
            stage_start <= '0;
            stage_end   <= '0;
            stage_count <= '0;
        end else if (setup_valid_i && setup_ready_o && !flush_i) begin
            stage_loop  <= setup_loop_i;
            stage_start <= setup_start_i;
            stage_end   <= setup_end_i;
            stage_count <= setup_count_i;
        end
    end

    // Context update: flush beats everything, commit beats a same-loop decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LOOPS; i++) ctx_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < N_LOOPS; i++) ctx_q[i].active <= 1'b0;
        end else begin
            for (int i = 0; i < N_LOOPS; i++) begin
                if ((state_q == COMMIT) && (stage_loop == IDX_W'(i))) begin
                    ctx_q[i] <= '{start: stage_start, end_addr: stage_end,
                                  count: stage_count, active: 1'b1};
                end else if (hit && (win_idx == IDX_W'(i))) begin
                    if (win_count > 32'd1) begin
                        ctx_q[i].count <= win_count - 32'd1;
                    end else begin
                        ctx_q[i].count  <= 32'd0;
                        ctx_q[i].active <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// tb/tb_riscv_hwloop_sequencer.sv - directed self-checking bench for riscv_hwloop_sequencer
module tb_riscv_hwloop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_pc;
    logic        pc_valid;
    logic        setup_valid;
    logic        setup_ready;
    logic [0:0]  setup_loop;
    logic [31:0] setup_start, setup_end, setup_count;
    logic        setup_err;
    logic        flush;
    logic        hwlp_jump;
    logic [31:0] hwlp_targ_addr;
    logic [1:0]  active;

    int errors = 0;
    int checks = 0;

    riscv_hwloop_sequencer #(.N_LOOPS(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .current_pc_i     (current_pc),
        .pc_valid_i       (pc_valid),
        .setup_valid_i    (setup_valid),
        .setup_ready_o    (setup_ready),
        .setup_loop_i     (setup_loop),
        .setup_start_i    (setup_start),
        .setup_end_i      (setup_end),
        .setup_count_i    (setup_count),
        .setup_err_o      (setup_err),
        .flush_i          (flush),
        .hwlp_jump_o      (hwlp_jump),
        .hwlp_targ_addr_o (hwlp_targ_addr),
        .active_o         (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge in CHECK.
    task automatic setup_req(input logic lp, input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] c, input logic exp_err);
        setup_valid = 1'b1;
        setup_loop  = lp;
        setup_start = s;
        setup_end   = e;
        setup_count = c;
        @(negedge clk);
        setup_valid = 1'b0;
        check("err_in_check", {31'd0, setup_err}, {31'd0, exp_err});
        check("ready_in_check", {31'd0, setup_ready}, 32'd0);
    endtask

    task automatic commit_wait();
        @(negedge clk);
        @(negedge clk);
    endtask

    // One PC visit: check the combinational jump, then let the edge consume it.
    task automatic visit(input string tag, input logic [31:0] pc, input logic exp_jump,
                         input logic [31:0] exp_targ);
        current_pc = pc;
        pc_valid   = 1'b1;
        #1;
        check({tag, "_jump"}, {31'd0, hwlp_jump}, {31'd0, exp_jump});
        check({tag, "_targ"}, hwlp_targ_addr, exp_targ);
        @(negedge clk);
        pc_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; current_pc = '0; pc_valid = 1'b0; setup_valid = 1'b0;
        setup_loop = '0; setup_start = '0; setup_end = '0; setup_count = '0; flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, setup_ready}, 32'd0);
        check("rst_err", {31'd0, setup_err}, 32'd0);
        check("rst_jump", {31'd0, hwlp_jump}, 32'd0);
        check("rst_targ", hwlp_targ_addr, 32'd0);
        check("rst_active", {30'd0, active}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, setup_ready}, 32'd1);

        // Basic loop: count 3 -> two jumps then fall through
        setup_req(1'b0, 32'h100, 32'h10C, 32'd3, 1'b0);
        @(negedge clk);
        check("active_in_commit", {30'd0, active}, 32'd0);
        @(negedge clk);
        check("active_after_commit", {30'd0, active}, 32'd1);
        visit("nomatch", 32'h108, 1'b0, 32'h0);
        visit("l0_v1", 32'h10C, 1'b1, 32'h100);
        visit("l0_v2", 32'h10C, 1'b1, 32'h100);
        visit("l0_v3", 32'h10C, 1'b0, 32'h0);
        check("l0_exit_active", {30'd0, active}, 32'd0);

        // Rejections
        setup_req(1'b0, 32'h100, 32'h10C, 32'd0, 1'b1);
        @(negedge clk);
        check("rej_cnt0_err_clear", {31'd0, setup_err}, 32'd0);
        check("rej_cnt0_ready", {31'd0, setup_ready}, 32'd1);
        check("rej_cnt0_active", {30'd0, active}, 32'd0);
        setup_req(1'b0, 32'h100, 32'h100, 32'd5, 1'b1);
        @(negedge clk);
        check("rej_eq_ready", {31'd0, setup_ready}, 32'd1);
        check("rej_eq_active", {30'd0, active}, 32'd0);
        setup_req(1'b0, 32'h102, 32'h10C, 32'd5, 1'b1);
        @(negedge clk);
        setup_req(1'b1, 32'h100, 32'h10E, 32'd5, 1'b1);
        @(negedge clk);
        setup_req(1'b1, 32'h110, 32'h100, 32'd2, 1'b1);
        @(negedge clk);
        check("rej_all_active", {30'd0, active}, 32'd0);

        // Nested loops sharing an end address: innermost wins, outer untouched
        setup_req(1'b0, 32'h200, 32'h20C, 32'd2, 1'b0);
        commit_wait();
        setup_req(1'b1, 32'h1F0, 32'h20C, 32'd5, 1'b0);
        commit_wait();
        check("nest_active", {30'd0, active}, 32'd3);
        visit("nest_v1", 32'h20C, 1'b1, 32'h200);
        visit("nest_v2", 32'h20C, 1'b0, 32'h0);
        check("nest_inner_exit", {30'd0, active}, 32'd2);
        for (int k = 0; k < 5; k++)
            visit("outer", 32'h20C, (k < 4), (k < 4) ? 32'h1F0 : 32'h0);
        check("nest_outer_exit", {30'd0, active}, 32'd0);

        // Commit coincides with a decrement of the same loop
        setup_req(1'b0, 32'h300, 32'h30C, 32'd4, 1'b0);
        commit_wait();
        setup_req(1'b0, 32'h300, 32'h30C, 32'd7, 1'b0);
        @(negedge clk);
        visit("coll", 32'h30C, 1'b1, 32'h300);
        check("coll_active", {30'd0, active}, 32'd1);
        for (int k = 0; k < 7; k++)
            visit("coll_cnt", 32'h30C, (k < 6), (k < 6) ? 32'h300 : 32'h0);
        check("coll_exit", {30'd0, active}, 32'd0);

        // Reset during CHECK abandons the pending setup
        setup_req(1'b0, 32'h400, 32'h40C, 32'd2, 1'b0);
        commit_wait();
        setup_req(1'b1, 32'h500, 32'h50C, 32'd3, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_chk_active", {30'd0, active}, 32'd0);
        check("rst_chk_ready", {31'd0, setup_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_chk_nowrite", {30'd0, active}, 32'd0);
        check("rst_chk_idle", {31'd0, setup_ready}, 32'd1);
        visit("rst_chk_pc", 32'h50C, 1'b0, 32'h0);

        // Flush with both loops active
        setup_req(1'b0, 32'h600, 32'h60C, 32'd3, 1'b0);
        commit_wait();
        setup_req(1'b1, 32'h700, 32'h70C, 32'd3, 1'b0);
        commit_wait();
        check("flush_pre", {30'd0, active}, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_active", {30'd0, active}, 32'd0);

        // Flush during CHECK discards the staged request
        setup_req(1'b0, 32'h800, 32'h80C, 32'd3, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        check("flush_chk_active", {30'd0, active}, 32'd0);
        check("flush_chk_ready", {31'd0, setup_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_hwloop_sequencer.md
RISCV_HWLOOP_SEQUENCER -- requirements
Module: riscv_hwloop_sequencer

Interface
REQ-001 Parameter N_LOOPS, default 2, SHALL set the number of hardware-loop contexts (legal values 1..4).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 current_pc_i  input  32  SHALL be the PC of the instruction in ID.
REQ-005 pc_valid_i  input  1  SHALL qualify current_pc_i as advancing this cycle.
REQ-006 setup_valid_i  input  1  SHALL be the setup request valid.
REQ-007 setup_ready_o  output  1  SHALL be the setup request ready.
REQ-008 setup_loop_i  input  $clog2(N_LOOPS) (min 1)  SHALL be the target loop index.
REQ-009 setup_start_i, setup_end_i, setup_count_i  input  32 each  SHALL be the loop start address, end address and iteration count.
REQ-010 setup_err_o  output  1  SHALL be a one-cycle pulse when a setup request is rejected.
REQ-011 flush_i  input  1  SHALL be the synchronous clear of all loop contexts.
REQ-012 hwlp_jump_o  output  1  SHALL request a jump to hwlp_targ_addr_o.
REQ-013 hwlp_targ_addr_o  output  32  SHALL be the jump target.
REQ-014 active_o  output  N_LOOPS  SHALL be the per-loop active flags.

Function
REQ-015 Each loop context SHALL hold start[31:0], end[31:0], count[31:0] and active.
REQ-016 The setup FSM SHALL have three states: IDLE, CHECK and COMMIT; setup_ready_o SHALL be 1 only in IDLE.
REQ-017 In IDLE, setup_valid_i & setup_ready_o SHALL capture all setup_* inputs into staging registers and move the FSM to CHECK.
REQ-018 In CHECK, the request SHALL be rejected if count==0, end<=start (unsigned), start[1:0]!=0, end[1:0]!=0, or loop index>=N_LOOPS.
REQ-019 On rejection, setup_err_o SHALL pulse in the CHECK cycle, no context SHALL change, and the FSM SHALL move to IDLE.
REQ-020 An accepted request in CHECK SHALL move the FSM to COMMIT.
REQ-021 In COMMIT, the staged start, end and count SHALL be written to the target context, active SHALL be set, and the FSM SHALL move to IDLE.
REQ-022 The new context SHALL be visible to jump evaluation in the cycle after COMMIT, giving a setup latency of 3 cycles from acceptance to active_o high.
REQ-023 Jump evaluation SHALL be combinational: loop i matches when pc_valid_i & active[i] & (current_pc_i==end[i]).
REQ-024 If several loops match, the lowest index (innermost loop) SHALL win; only the winner is acted on.
REQ-025 If the winner's count>1, hwlp_jump_o SHALL be 1, hwlp_targ_addr_o SHALL be start[winner], and count SHALL decrement by 1 at the clock edge.
REQ-026 If the winner's count==1, hwlp_jump_o SHALL be 0, count SHALL become 0, and active SHALL clear at the clock edge (loop exit, fall through).
REQ-027 With no match, hwlp_jump_o SHALL be 0 and hwlp_targ_addr_o SHALL be 32'h0.
REQ-028 Count arithmetic SHALL be 32-bit unsigned; an active context never holds 0, so no decrement wrap is possible.
REQ-029 If COMMIT and a decrement target the same loop in the same cycle, the commit SHALL win and the decrement SHALL be discarded; hwlp_jump_o is still driven from the pre-commit state.
REQ-030 flush_i SHALL clear all active bits and return the FSM to IDLE, discarding any staged request; flush_i SHALL take priority over commit and decrement.
REQ-031 A setup to an already-active loop SHALL overwrite it.

Reset
REQ-032 rst high SHALL asynchronously set: FSM=IDLE, all active=0, all start/end/count=0, and staging=0.
REQ-033 While rst is high, outputs SHALL be: setup_ready_o=0, setup_err_o=0, hwlp_jump_o=0, hwlp_targ_addr_o=0, active_o=0.
REQ-034 After rst deasserts, setup_ready_o SHALL be 1 from the first clock edge; a reset in CHECK or COMMIT SHALL abandon the request with no write.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (IDLE/CHECK/COMMIT), the loop-context struct, and the address alignment mask constant.
REQ-036 One sub-module, riscv_hwloop_match, SHALL implement the per-context end-address compare and the lowest-index priority select.

Verification
REQ-037 Setup loop0 with start=0x100, end=0x10C, count=3, then drive PC=0x10C three times -> jumps to 0x100 twice, third visit no jump, active_o[0]=0.
REQ-038 Setup with count=0, or with end=0x100, start=0x100 -> setup_err_o pulses once, active_o unchanged, setup_ready_o returns to 1 the next cycle.
REQ-039 Loop0 (0x200..0x20C, count=2) and loop1 (0x1F0..0x20C, count=5), PC=0x20C -> loop0 wins with target 0x200, loop1 count stays 5.
REQ-040 COMMIT to loop0 with count=7 coincides with PC==end0 and count0=4 -> hwlp_jump_o=1 that cycle, count0=7 afterwards.
REQ-041 Assert rst during CHECK with a pending loop1 setup -> active_o=0, no write, FSM=IDLE; assert flush_i with both loops active -> active_o=0 next cycle.
